sdp_erdma_rd_cdt_gate: RTL
==========================

Name: sdp_erdma_rd_cdt_gate

Overview:
- Credit gate between the SDP ERDMA read-request output and the MCIF read-client port.
- Issues a read request only when the client latency FIFO in MCIF has room for every returned 32B atom.
- Consumes a credit on request issue and returns one credit per latency-FIFO pop, signalled back by ERDMA egress.
- Registers the request path (one pipe stage), flags credit protocol errors and reports idle for layer-switch logic.

Parameters:
- LAT_FIFO_DEPTH, 256, number of 32B atom entries in the MCIF latency FIFO, equal to the credit pool size.
- CDT_W, 9, width of the credit counter; must satisfy 2^CDT_W > LAT_FIFO_DEPTH.

Ports:
- nvdla_core_clk  in  1  core clock.
- nvdla_core_rstn  in  1  asynchronous active-low reset.
- op_load  in  1  layer-start pulse.
- req_in_valid  in  1  request from ERDMA ingress is valid.
- req_in_ready  out  1  request is accepted this cycle.
- req_in_pd  in  79  request: {size[14:0] = atoms-1, addr[63:0]}.
- req_out_valid  out  1  request to MCIF is valid.
- req_out_ready  in  1  MCIF accepts the request.
- req_out_pd  out  79  registered copy of req_in_pd.
- cdt_lat_fifo_pop  in  1  one atom popped from the latency FIFO; returns 1 credit.
- cdt_avail  out  CDT_W  current free credits.
- cdt_idle  out  1  all credits home and the pipe stage is empty.
- cdt_err  out  1  sticky credit-protocol error.
- dp2reg_cdt_stall  out  32  credit-stall perf counter (optional feature).

Behaviour:
- Reset values:
  - cdt_avail = LAT_FIFO_DEPTH.
  - req_out_valid = 0, req_out_pd = 0.
  - cdt_err = 0, dp2reg_cdt_stall = 0.
  - cdt_idle = 1.
- Cost of a request: cost = min(size+1, LAT_FIFO_DEPTH), computed in 16 bits.
  - If size+1 > LAT_FIFO_DEPTH, the request is still issued and cdt_err is set in the cycle it is accepted.
- Acceptance: req_in_ready = (!req_out_valid | req_out_ready) & (cdt_avail >= cost).
  - req_in_ready is combinational on req_in_pd and must not depend on req_in_valid.
- Pipe stage:
  - On accept, req_out_pd <= req_in_pd and req_out_valid <= 1 on the next edge. Latency is one cycle.
  - req_out_valid clears only when req_out_ready is high and no new accept happens in that cycle.
  - req_out_pd stays stable while req_out_valid & !req_out_ready.
- Credit update each cycle: cdt_avail <= cdt_avail - (accept ? cost : 0) + (cdt_lat_fifo_pop ? 1 : 0).
  - When accept and pop occur in the same cycle, both apply.
  - A credit returned by pop becomes usable the following cycle; there is no same-cycle bypass into the ready calculation.
- Overflow: a pop arriving when cdt_avail == LAT_FIFO_DEPTH and no accept occurs saturates cdt_avail at LAT_FIFO_DEPTH and sets cdt_err.
- Underflow cannot occur by construction. An assertion checks cdt_avail <= LAT_FIFO_DEPTH.
- cdt_idle = (cdt_avail == LAT_FIFO_DEPTH) & !req_out_valid. It is registered-derived, with no combinational path from the inputs.
- op_load:
  - Clears cdt_err and dp2reg_cdt_stall.
  - Does NOT touch cdt_avail or the pipe stage; credits from the previous layer drain naturally.
- Reset mid-operation: all state returns to reset values immediately. Outstanding pops after reset are treated as overflow and set cdt_err.
- No state machine beyond the pipe-valid bit. The credit counter is the only arithmetic path, and its width is checked against CDT_W.

Optional Feature:
- Macro: SDP_ERDMA_CDT_PERF_EN.
- Defined:
  - dp2reg_cdt_stall increments by 1 each cycle where req_in_valid & (!req_out_valid | req_out_ready) & (cdt_avail < cost), i.e. stalled on credit only.
  - Saturates at 32'hFFFF_FFFF and is cleared by op_load.
- Undefined: dp2reg_cdt_stall is tied to 0 and no counter flops are instantiated.

Test Plan:
- Reset then idle:
  - cdt_avail == 256, cdt_idle == 1, req_out_valid == 0.
  - Drive one pop → cdt_avail stays 256, cdt_err == 1.
  - Pulse op_load → cdt_err == 0.
- Single request size=3 with req_out_ready=1:
  - req_out_valid high exactly 1 cycle after accept, pd matches input.
  - cdt_avail == 252.
  - 4 pops → cdt_avail == 256, cdt_idle == 1.
- Exhaustion:
  - Issue 16 requests of size=15 → cdt_avail == 0.
  - 17th request held (req_in_ready == 0).
  - 15 pops → still held. 16th pop → accepted the cycle after the pop.
- Simultaneous events:
  - cdt_avail == 8, request size=7 accepted in the same cycle as a pop → cdt_avail == 1 next cycle.
- Backpressure: req_out_ready low for 5 cycles with a second request pending → req_out_pd stable, req_in_ready == 0, no credit deducted for the second request until the slot frees.
- With SDP_ERDMA_CDT_PERF_EN:
  - cdt_avail == 2, request size=7 held for 10 cycles → dp2reg_cdt_stall == 10.
  - op_load → 0.
  - Without the macro → dp2reg_cdt_stall remains 0 throughout.

Source files
------------

// File: rtl/sdp_erdma_rd_cdt_gate.sv
// SDP ERDMA read-request credit gate toward the MCIF latency FIFO.
// Optional stall perf counter: define SDP_ERDMA_CDT_PERF_EN.
module sdp_erdma_rd_cdt_gate #(
  parameter int LAT_FIFO_DEPTH = 256,
  parameter int CDT_W = 9
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             op_load,
  input  logic             req_in_valid,
  output logic             req_in_ready,
  input  logic [78:0]      req_in_pd,
  output logic             req_out_valid,
  input  logic             req_out_ready,
  output logic [78:0]      req_out_pd,
  input  logic             cdt_lat_fifo_pop,
  output logic [CDT_W-1:0] cdt_avail,
  output logic             cdt_idle,
  output logic             cdt_err,
  output logic [31:0]      dp2reg_cdt_stall
);

  localparam logic [15:0] DEPTH16 = 16'(LAT_FIFO_DEPTH);
  localparam logic [CDT_W-1:0] DEPTH_C = CDT_W'(LAT_FIFO_DEPTH);
  localparam bit CDT_W_OK = (2 ** CDT_W) > LAT_FIFO_DEPTH;

  logic [15:0] cost_raw;
  logic [15:0] cost;
  logic [15:0] avail16;
  logic [15:0] avail_nxt;
  logic        oversize;
  logic        slot_free;
  logic        credit_ok;
  logic        accept;
  logic        pop_ovf;

  assign cost_raw  = {1'b0, req_in_pd[78:64]} + 16'd1;
  assign oversize  = cost_raw > DEPTH16;
  assign cost      = oversize ? DEPTH16 : cost_raw;
  assign avail16   = 16'(cdt_avail);
  assign slot_free = !req_out_valid | req_out_ready;
  assign credit_ok = avail16 >= cost;

  assign req_in_ready = slot_free & credit_ok;
  assign accept       = req_in_valid & req_in_ready;

  // A pop with a full pool and no accept has nowhere to go
  assign pop_ovf   = cdt_lat_fifo_pop & !accept & (cdt_avail == DEPTH_C);
  assign avail_nxt = avail16 - (accept ? cost : 16'd0)
                   + {15'd0, cdt_lat_fifo_pop};

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      cdt_avail <= DEPTH_C;
    end else if (!pop_ovf) begin
      cdt_avail <= CDT_W'(avail_nxt);
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      req_out_valid <= 1'b0;
      req_out_pd    <= '0;
    end else if (accept) begin
      req_out_valid <= 1'b1;
      req_out_pd    <= req_in_pd;
    end else if (req_out_ready) begin
      req_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      cdt_err <= 1'b0;
    end else if ((accept & oversize) | pop_ovf) begin
      cdt_err <= 1'b1;
    end else if (op_load) begin
      cdt_err <= 1'b0;
    end
  end

  assign cdt_idle = (cdt_avail == DEPTH_C) & !req_out_valid;

`ifdef SDP_ERDMA_CDT_PERF_EN
  logic [31:0] stall_cnt;
  logic        stall;

  assign stall = req_in_valid & slot_free & !credit_ok;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      stall_cnt <= '0;
    end else if (op_load) begin
      stall_cnt <= '0;
    end else if (stall && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign dp2reg_cdt_stall = stall_cnt;
`else
  assign dp2reg_cdt_stall = 32'd0;
`endif

  a_cdt_w_ok : assert property (
    @(posedge nvdla_core_clk) CDT_W_OK);

  a_cdt_range : assert property (
    @(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    avail16 <= DEPTH16);

endmodule
